muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the 32-bit MIPS-style datapath.
- Sits upstream of the 32-bit writeback 2:1 selector: hi or lo (chosen by the decode-driven hilo_sel) feeds port1 of that selector, and the ALU result feeds port0.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and supports MTHI/MTLO direct writes.
- The pipeline stalls on busy.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_core.sv | 88 ++++++++
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // LO value written on divide-by-zero
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the issue stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             hilo_sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rdata;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata, hilo_sel,
    input  busy, done, hi, lo, rdata
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata, hilo_sel,
    output busy, done, hi, lo, rdata
  );
endinterface

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply (LSB first) and restoring
// divide (MSB first), one bit per step.
module muldiv_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               last
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // acc: mult -> {partial product, remaining multiplier}; div -> low half holds
  // the dividend shifting out and quotient bits shifting in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               div_q, div_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH+1:0]   rem_sh;
  logic [WIDTH+1:0]   diff;

  // Per-iteration step and operand load
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    rem_d  = rem_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = {rem_q, acc_q[WIDTH-1]};
    diff   = rem_sh - {2'b00, opnd_q};
    if (load) begin
      acc_d  = {{WIDTH{1'b0}}, (is_div ? opa : opb)};
      opnd_d = is_div ? opb : opa;
      rem_d  = '0;
      div_d  = is_div;
      cnt_d  = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        // Borrow out of the trial subtraction means restore
        if (!diff[WIDTH+1]) begin
          rem_d              = diff[WIDTH:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d              = rem_sh[WIDTH:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      rem_q  <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

  assign prod = acc_q;
  assign quot = acc_q[WIDTH-1:0];
  assign rem  = rem_q[WIDTH-1:0];
  assign last = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with architectural HI/LO: control FSM, sign handling,
// MTHI/MTLO writes and the HI/LO read select.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic               load, step, last;
  logic               signed_op, op_is_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot, rem;

  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign abs_a     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign prod_fix  = (sign_a_q ^ sign_b_q) ? -prod : prod;

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (bus.op[1]),
    .opa    (abs_a),
    .opb    (abs_b),
    .prod   (prod),
    .quot   (quot),
    .rem    (rem),
    .last   (last)
  );

  // Next-state, operand capture and HI/LO update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    a_raw_d  = a_raw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          load     = 1'b1;
          op_d     = bus.op;
          sign_a_d = signed_op & bus.a[WIDTH-1];
          sign_b_d = signed_op & bus.b[WIDTH-1];
          b_zero_d = (bus.b == '0);
          a_raw_d  = bus.a;
          state_d  = StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (last) state_d = StFix;
      end
      StFix: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (op_is_div) begin
          if (b_zero_q) begin
            // Divide by zero returns all-ones quotient and the raw dividend
            lo_d = WIDTH'(DIV0_LO);
            hi_d = a_raw_q;
          end else begin
            lo_d = (sign_a_q ^ sign_b_q) ? -quot : quot;
            hi_d = sign_a_q ? -rem : rem;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      a_raw_q  <= a_raw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.rdata = bus.hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int busy_cyc;
  int done_cnt;
  logic [31:0] res_hi, res_lo;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(
    .WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_0000;
    bus.b     = 32'h0000_DEAD;
    bus.op    = 2'b00;
  endtask

  // Counts busy cycles from just after the accepting edge until busy drops,
  // capturing hi/lo at the first idle cycle and counting done pulses.
  task automatic wait_done();
    int n;
    busy_cyc = 0;
    done_cnt = 0;
    n        = 0;
    while (bus.busy && n < 100) begin
      busy_cyc++;
      if (bus.done) done_cnt++;
      tick();
      n++;
    end
    res_hi = bus.hi;
    res_lo = bus.lo;
    if (bus.done) done_cnt++;
    tick();
    if (bus.done) done_cnt++;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start_op(o, x, y);
    wait_done();
  endtask

  initial begin
    int seen;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.a        = '0;
    bus.b        = '0;
    bus.hi_we    = 1'b0;
    bus.lo_we    = 1'b0;
    bus.wdata    = '0;
    bus.hilo_sel = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    rst = 1'b0;

    // MTHI / MTLO in IDLE
    bus.hi_we = 1'b1; bus.wdata = 32'hA5A5_A5A5; bus.hilo_sel = 1'b1;
    tick();
    bus.hi_we = 1'b0;
    check("mthi_hi", bus.hi, 32'hA5A5_A5A5);
    check("mthi_rdata", bus.rdata, 32'hA5A5_A5A5);
    bus.lo_we = 1'b1; bus.wdata = 32'h5A5A_1234; bus.hilo_sel = 1'b0;
    tick();
    bus.lo_we = 1'b0;
    check("mtlo_lo", bus.lo, 32'h5A5A_1234);
    check("mtlo_rdata", bus.rdata, 32'h5A5A_1234);

    // Reset mid-DIV: abandoned, no result, hi/lo cleared
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) seen++;
      tick();
    end
    check("midrst_no_done", seen, 32'd0);

    // DIVU 100/7 after reset
    run_op(2'b11, 32'd100, 32'd7);
    check("divu_lo", res_lo, 32'd14);
    check("divu_hi", res_hi, 32'd2);

    // MULTU max*max, with latency
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", res_hi, 32'hFFFF_FFFE);
    check("multu_lo", res_lo, 32'h0000_0001);
    check("multu_busy_cyc", busy_cyc, 32'd33);
    check("multu_done_cnt", done_cnt, 32'd1);

    // MULT -3 * 7
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_hi", res_hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", res_lo, 32'hFFFF_FFEB);

    // MULT with most-negative operand
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    check("mult_min2_hi", res_hi, 32'h4000_0000);
    check("mult_min2_lo", res_lo, 32'h0000_0000);
    run_op(2'b00, 32'h8000_0000, 32'd1);
    check("mult_min1_hi", res_hi, 32'hFFFF_FFFF);
    check("mult_min1_lo", res_lo, 32'h8000_0000);

    // DIV -7 / 2
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo", res_lo, 32'hFFFF_FFFD);
    check("div_neg_hi", res_hi, 32'hFFFF_FFFF);
    check("div_busy_cyc", busy_cyc, 32'd33);
    check("div_done_cnt", done_cnt, 32'd1);

    // Divide by zero, unsigned and signed
    run_op(2'b11, 32'h1234_5678, 32'd0);
    check("divu0_lo", res_lo, 32'hFFFF_FFFF);
    check("divu0_hi", res_hi, 32'h1234_5678);
    check("divu0_busy_cyc", busy_cyc, 32'd33);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0);
    check("div0_lo", res_lo, 32'hFFFF_FFFF);
    check("div0_hi", res_hi, 32'hFFFF_FFFB);

    // DIV overflow case
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", res_lo, 32'h8000_0000);
    check("div_ovf_hi", res_hi, 32'h0000_0000);

    // start and MTHI while busy are ignored
    bus.hi_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
    tick();
    bus.hi_we = 1'b0;
    start_op(2'b01, 32'd2, 32'd3);
    repeat (5) tick();
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd50; bus.b = 32'd5;
    bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0;
    check("busy_mthi_ignored", bus.hi, 32'hA5A5_A5A5);
    wait_done();
    check("busy_res_hi", res_hi, 32'd0);
    check("busy_res_lo", res_lo, 32'd6);
    check("busy_done_cnt", done_cnt, 32'd1);
    check("busy_start_dropped", {31'b0, bus.busy}, 32'd0);
    bus.hilo_sel = 1'b0;
    #1;
    check("final_rdata_lo", bus.rdata, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
